// File: rtl/lrn_sqsum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lrn_sqsum_pkg
//  Description : Shared constants, width helpers and FSM encoding for the
//                LRN square-sum producer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lrn_sqsum_pkg;

    // Default datapath configuration
    localparam int OP_WIDTH_DEF  = 16;
    localparam int NUM_PE_DEF    = 4;
    localparam int FRAC_BITS_DEF = 8;
    localparam int WINDOW_DEF    = 5;

    // Half window: channels on each side of the centre tap
    function automatic int lrn_h(input int window);
        return (window - 1) / 2;
    endfunction

    // Width of one squared activation after the fixed-point realignment
    function automatic int lrn_sq_width(input int op_width, input int frac_bits);
        return 2 * op_width - frac_bits;
    endfunction

    // Width of the running window sum (square width plus growth for WINDOW terms)
    function automatic int lrn_sum_width(input int op_width, input int frac_bits,
                                         input int window);
        return lrn_sq_width(op_width, frac_bits) + $clog2(window);
    endfunction

    localparam int H         = lrn_h(WINDOW_DEF);
    localparam int SQ_WIDTH  = lrn_sq_width(OP_WIDTH_DEF, FRAC_BITS_DEF);
    localparam int SUM_WIDTH = lrn_sum_width(OP_WIDTH_DEF, FRAC_BITS_DEF, WINDOW_DEF);

    // Flush counter width; WINDOW <= 9 keeps H <= 4
    localparam int FCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage : lrn_sqsum_pkg
`default_nettype wire

// File: rtl/lrn_sqsum_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lrn_sqsum_lane
//  Description : One lane of the square-sum datapath: square stage (S1),
//                WINDOW-deep shift register with running sum (S2) and
//                saturation of the window sum to OP_WIDTH bits.
//  Ports       : clk, reset (async active-low)
//                ld_i     - load S1 with x_i and its square
//                x_i      - activation (zero during flush steps)
//                sh_i     - shift S1 into the window and update the sum
//                clr_i    - group clear of window and sum
//                center_o - activation at the centre tap
//                sat_o    - saturated window sum
//  Revision    : 1.0 - initial release
// ============================================================================
module lrn_sqsum_lane
    import lrn_sqsum_pkg::*;
#(
    parameter int OP_WIDTH  = OP_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int WINDOW    = WINDOW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_i,
    input  logic [OP_WIDTH-1:0] x_i,
    input  logic                sh_i,
    input  logic                clr_i,
    output logic [OP_WIDTH-1:0] center_o,
    output logic [OP_WIDTH-1:0] sat_o
);

    localparam int HALF  = lrn_h(WINDOW);
    localparam int SQ_W  = lrn_sq_width(OP_WIDTH, FRAC_BITS);
    localparam int SUM_W = lrn_sum_width(OP_WIDTH, FRAC_BITS, WINDOW);

    logic signed [2*OP_WIDTH-1:0] w_prod;
    logic        [SQ_W-1:0]       w_sq;

    logic [OP_WIDTH-1:0] s1_x_q;
    logic [SQ_W-1:0]     s1_sq_q;
    // Only taps 0..HALF need the activation; the sum needs every square
    logic [OP_WIDTH-1:0] win_x_q  [HALF+1];
    logic [SQ_W-1:0]     win_sq_q [WINDOW];
    logic [SUM_W-1:0]    sum_q;

    // Square of a signed value is non-negative, so the shifted product
    // fits the unsigned square width without loss.
    assign w_prod = $signed(x_i) * $signed(x_i);
    assign w_sq   = SQ_W'(w_prod >> FRAC_BITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_x_q  <= '0;
            s1_sq_q <= '0;
        end else if (ld_i) begin
            s1_x_q  <= x_i;
            s1_sq_q <= w_sq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= HALF; i++) win_x_q[i] <= '0;
            for (int i = 0; i < WINDOW; i++) win_sq_q[i] <= '0;
            sum_q <= '0;
        end else if (clr_i) begin
            // A new group's first entry may shift in on the clearing edge;
            // it then becomes the only occupant of the window.
            for (int i = 0; i <= HALF; i++) win_x_q[i] <= '0;
            for (int i = 0; i < WINDOW; i++) win_sq_q[i] <= '0;
            sum_q <= '0;
            if (sh_i) begin
                win_x_q[0]  <= s1_x_q;
                win_sq_q[0] <= s1_sq_q;
                sum_q       <= SUM_W'(s1_sq_q);
            end
        end else if (sh_i) begin
            win_x_q[0]  <= s1_x_q;
            win_sq_q[0] <= s1_sq_q;
            for (int i = 1; i <= HALF; i++) win_x_q[i] <= win_x_q[i-1];
            for (int i = 1; i < WINDOW; i++) win_sq_q[i] <= win_sq_q[i-1];
            // The outgoing square is always part of the sum, so this never underflows
            sum_q <= sum_q + SUM_W'(s1_sq_q) - SUM_W'(win_sq_q[WINDOW-1]);
        end
    end

    assign center_o = win_x_q[HALF];
    assign sat_o    = (|sum_q[SUM_W-1:OP_WIDTH]) ? {OP_WIDTH{1'b1}} : sum_q[OP_WIDTH-1:0];

endmodule : lrn_sqsum_lane
`default_nettype wire

// File: rtl/lrn_sqsum.sv
`default_nettype none
// ============================================================================
//  Module      : lrn_sqsum
//  Description : LRN producer. Streams NUM_PE-lane channel words, computes the
//                zero-padded cross-channel sum of squares over WINDOW channels
//                and emits it with the centre activation as a one-cycle pulse.
//  Ports       : clk, reset (async active-low)
//                in_valid/in_ready/in_data/in_last - input stream, one channel
//                per beat, in_last closes the group
//                square_sum  - per-lane saturated window sum
//                lrn_center  - per-lane centre activation
//                out_valid   - single-cycle qualifier, no backpressure
//                busy        - FSM active or pipeline holds a valid entry
//  Revision    : 1.0 - initial release
// ============================================================================
module lrn_sqsum
    import lrn_sqsum_pkg::*;
#(
    parameter int OP_WIDTH  = OP_WIDTH_DEF,
    parameter int NUM_PE    = NUM_PE_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int WINDOW    = WINDOW_DEF      // odd, 3..9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_WIDTH*NUM_PE-1:0]   in_data,
    input  logic                         in_last,
    output logic [OP_WIDTH*NUM_PE-1:0]   square_sum,
    output logic [OP_WIDTH*NUM_PE-1:0]   lrn_center,
    output logic                         out_valid,
    output logic                         busy
);

    localparam int HALF = lrn_h(WINDOW);
    localparam int DW   = OP_WIDTH * NUM_PE;

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                w_accept;
    logic                w_flush_step;
    logic                w_flush_last;
    logic                w_ld;

    logic                s1_ld_q;     // S1 holds an entry to shift next edge
    logic                s1_bit_q;    // valid bit of that entry (0 for padding)
    logic                sh_pulse_q;  // window shifted on the previous edge
    logic                clr1_q;
    logic                clr2_q;
    logic [HALF:0]       vchain_q;    // valid bits for window taps 0..HALF

    logic [DW-1:0]       w_center;
    logic [DW-1:0]       w_sat;
    logic [DW-1:0]       square_sum_q;
    logic [DW-1:0]       lrn_center_q;
    logic                out_valid_q;

    // ------------------------------------------------------------------
    // Handshake and FSM
    // ------------------------------------------------------------------
    assign in_ready     = reset & (state_q != ST_FLUSH);
    assign w_accept     = in_valid & in_ready;
    assign w_flush_step = (state_q == ST_FLUSH);
    assign w_flush_last = w_flush_step && (fcnt_q == FCNT_W'(HALF - 1));
    assign w_ld         = w_accept | w_flush_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) state_d = in_last ? ST_FLUSH : ST_RUN;
            end
            ST_RUN: begin
                if (w_accept && in_last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_flush_last) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control. The group clear is delayed two edges past the
    // last flush step so the final channel can still be read from the
    // window; it lands on the edge a following group's first entry
    // would shift in.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_ld_q    <= 1'b0;
            s1_bit_q   <= 1'b0;
            sh_pulse_q <= 1'b0;
            clr1_q     <= 1'b0;
            clr2_q     <= 1'b0;
            vchain_q   <= '0;
        end else begin
            s1_ld_q    <= w_ld;
            s1_bit_q   <= w_accept;
            sh_pulse_q <= s1_ld_q;
            clr1_q     <= w_flush_last;
            clr2_q     <= clr1_q;
            if (clr2_q)
                vchain_q <= {{HALF{1'b0}}, s1_ld_q & s1_bit_q};
            else if (s1_ld_q)
                vchain_q <= {vchain_q[HALF-1:0], s1_bit_q};
        end
    end

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
        logic [OP_WIDTH-1:0] w_x;
        assign w_x = w_accept ? in_data[gi*OP_WIDTH +: OP_WIDTH] : '0;

        lrn_sqsum_lane #(
            .OP_WIDTH  (OP_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .WINDOW    (WINDOW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .ld_i     (w_ld),
            .x_i      (w_x),
            .sh_i     (s1_ld_q),
            .clr_i    (clr2_q),
            .center_o (w_center[gi*OP_WIDTH +: OP_WIDTH]),
            .sat_o    (w_sat[gi*OP_WIDTH +: OP_WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // Output registers: capture only when the centre tap just received
    // a real channel, so each channel yields exactly one pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            square_sum_q <= '0;
            lrn_center_q <= '0;
        end else begin
            out_valid_q <= sh_pulse_q & vchain_q[HALF];
            if (sh_pulse_q && vchain_q[HALF]) begin
                square_sum_q <= w_sat;
                lrn_center_q <= w_center;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign square_sum = square_sum_q;
    assign lrn_center = lrn_center_q;
    assign busy       = (state_q != ST_IDLE) | s1_ld_q | (|vchain_q);

endmodule : lrn_sqsum
`default_nettype wire
